// File: rtl/button_debouncer.sv
// Synchronises, debounces and edge-detects N push-buttons. Each channel produces a clean level,
// press/release pulses and a long-press pulse and level.
module button_debouncer #(
    parameter int unsigned N      = 3,
    parameter int unsigned T      = 1000 * 1000,
    parameter int unsigned LONG_T = 50 * 1000 * 1000,
    parameter logic        INVERT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_state,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_press,
    output logic [N-1:0] long_held
);

    localparam int unsigned CW = (T > 1) ? $clog2(T + 1) : 1;
    localparam int unsigned HW = (LONG_T > 1) ? $clog2(LONG_T + 1) : 1;
    localparam logic [CW-1:0] CntLast  = CW'(T - 1);
    localparam logic [HW-1:0] HoldMax  = HW'(LONG_T);
    localparam logic [HW-1:0] HoldLast = HW'(LONG_T - 1);

    typedef enum logic [1:0] {StLow, StRiseWait, StHigh, StFallWait} state_e;

    logic [N-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in ^ {N{INVERT}};
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_e        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [HW-1:0] hold_q, hold_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          lp_q, lp_d;
        logic          lh_q, lh_d;
        logic          s;

        assign s = sync2_q[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            unique case (state_q)
                StLow: begin
                    if (s) begin
                        if (T == 1) begin
                            state_d = StHigh;
                            level_d = 1'b1;
                            press_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = StRiseWait;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                StRiseWait: begin
                    if (!s) begin
                        state_d = StLow;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StHigh;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StHigh: begin
                    if (!s) begin
                        if (T == 1) begin
                            state_d = StLow;
                            level_d = 1'b0;
                            rel_d   = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = StFallWait;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                StFallWait: begin
                    if (s) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StLow;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StLow;
            endcase

            // Hold counter follows the registered level, so FALL_WAIT bounces keep their credit
            hold_d = hold_q;
            lp_d   = 1'b0;
            lh_d   = lh_q;
            if (!level_q) begin
                hold_d = '0;
            end else if (hold_q != HoldMax) begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HoldLast && !rel_d) begin
                    lp_d = 1'b1;
                    lh_d = 1'b1;
                end
            end
            if (rel_d) lh_d = 1'b0;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= StLow;
                cnt_q   <= '0;
                hold_q  <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                lp_q    <= 1'b0;
                lh_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hold_q  <= hold_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                lp_q    <= lp_d;
                lh_q    <= lh_d;
            end
        end

        assign btn_state[i]     = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = rel_q;
        assign long_press[i]    = lp_q;
        assign long_held[i]     = lh_q;
    end

endmodule
